cache_tag_ctrl_4way: RTL

Tag store and lookup/miss controller for the 4-way set-associative cache.
- Holds per-set tags, invalid bits and pseudo-LRU state.
- Drives the selected set's four tags and invalid flags to the combinational hit/miss comparator, samples its Hit/way result, and on a miss fetches from memory, then refills the victim way.
- Sits between the CPU-side request port and the hit/miss comparator and memory interface.

---
 rtl/cache_tag_ctrl_4way.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/cache_tag_ctrl_4way.sv
// Tag store and lookup/miss controller for a 4-way set-associative cache.
// Holds per-set tags, invalid bits and tree-PLRU state; refills victim ways after memory fetch.
module cache_tag_ctrl_4way #(
  parameter int TAG_W = 12,
  parameter int IDX_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [TAG_W+IDX_W-1:0] req_addr,
  output logic [TAG_W-1:0]       tag_w0,
  output logic [TAG_W-1:0]       tag_w1,
  output logic [TAG_W-1:0]       tag_w2,
  output logic [TAG_W-1:0]       tag_w3,
  output logic                   inv_w0,
  output logic                   inv_w1,
  output logic                   inv_w2,
  output logic                   inv_w3,
  output logic [TAG_W-1:0]       cmp_addr,
  input  logic                   hit_in,
  input  logic [1:0]             hit_way_in,
  output logic                   mem_req,
  output logic [TAG_W+IDX_W-1:0] mem_addr,
  input  logic                   mem_ack,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic [1:0]             resp_way
);

  localparam int AW    = TAG_W + IDX_W;
  localparam int NSETS = 1 << IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS,
    FILL,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0]    lat_addr;
  logic [IDX_W-1:0] set_idx;
  logic [TAG_W-1:0] lat_tag;
  logic             hit_r;
  logic [1:0]       way_r;

  logic [TAG_W-1:0] tag_mem  [NSETS][4];
  logic [3:0]       inv_mem  [NSETS];
  logic [2:0]       plru_mem [NSETS];

  logic [3:0]       cur_inv;
  logic [2:0]       cur_plru;
  logic [1:0]       victim;
  logic             plru_we;
  logic [1:0]       plru_way;
  logic             fill_we;

  assign set_idx  = lat_addr[IDX_W-1:0];
  assign lat_tag  = lat_addr[AW-1:IDX_W];
  assign cur_inv  = inv_mem[set_idx];
  assign cur_plru = plru_mem[set_idx];

  assign tag_w0   = tag_mem[set_idx][0];
  assign tag_w1   = tag_mem[set_idx][1];
  assign tag_w2   = tag_mem[set_idx][2];
  assign tag_w3   = tag_mem[set_idx][3];
  assign inv_w0   = cur_inv[0];
  assign inv_w1   = cur_inv[1];
  assign inv_w2   = cur_inv[2];
  assign inv_w3   = cur_inv[3];
  assign cmp_addr = lat_tag;
  assign mem_addr = lat_addr;
  assign resp_hit = hit_r;
  assign resp_way = way_r;

  // Point the tree away from the way just used: root to the other half, pair bit to the sibling.
  function automatic logic [2:0] plru_touch(input logic [2:0] bits, input logic [1:0] way);
    logic [2:0] r;
    r = bits;
    case (way)
      2'd0: begin r[0] = 1'b1; r[1] = 1'b1; end
      2'd1: begin r[0] = 1'b1; r[1] = 1'b0; end
      2'd2: begin r[0] = 1'b0; r[2] = 1'b1; end
      default: begin r[0] = 1'b0; r[2] = 1'b0; end
    endcase
    return r;
  endfunction

  // Lowest-index invalid way wins; the descending loop lets lower ways overwrite higher ones.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    victim = cur_plru[0] ? (cur_plru[2] ? 2'd3 : 2'd2) : (cur_plru[1] ? 2'd1 : 2'd0);
    for (int w = 3; w >= 0; w--) begin
      if (cur_inv[w]) victim = 2'(w);
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    mem_req    = 1'b0;
    resp_valid = 1'b0;
    plru_we    = 1'b0;
    plru_way   = way_r;
    fill_we    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (hit_in) begin
          plru_we   = 1'b1;
          plru_way  = hit_way_in;
          state_nxt = RESP;
        end else begin
          state_nxt = MISS;
        end
      end
      MISS: begin
        mem_req = 1'b1;
        if (mem_ack) state_nxt = FILL;
      end
      FILL: begin
        fill_we   = 1'b1;
        plru_we   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lat_addr <= '0;
      hit_r    <= 1'b0;
      way_r    <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state <= state_nxt;
      if (state == IDLE && req_valid) lat_addr <= req_addr;
      if (state == LOOKUP) begin
        hit_r <= hit_in;
        way_r <= hit_in ? hit_way_in : victim;
      end
    end
  end

  // NOTE: the tag/valid/PLRU store is reset on purpose: a cold cache must start with every way
  // invalid, so these arrays are flops with async clear rather than an uninitialised RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NSETS; s++) begin
        inv_mem[s]  <= '1;
        plru_mem[s] <= '0;
        for (int w = 0; w < 4; w++) tag_mem[s][w] <= '0;
      end
    end else begin
      if (fill_we) begin
        tag_mem[set_idx][way_r] <= lat_tag;
        inv_mem[set_idx][way_r] <= 1'b0;
      end
      if (plru_we) plru_mem[set_idx] <= plru_touch(cur_plru, plru_way);
    end
  end

endmodule
